pipeline_hazard_controller: RTL
===============================

// Module: pipeline_hazard_controller
// PURPOSE
//  Sequences the 5-stage pipeline register bank. Each cycle it generates per-stage stall/flush, PC enable and PC redirect from:
//  - load-use hazards,
//  - taken branches/jumps resolved in EX,
//  - multi-cycle EX operations (div),
//  - data-memory wait and instruction-fetch wait.
//  Keeps an FSM for in-flight multi-cycle ops, a watchdog, and performance counters. Sits beside the pipeline registers in the core top.
// PARAMETERS
//  MC_TIMEOUT   64   cycles in MC_WAIT before sticky mc_timeout_err is set
//  CNT_WIDTH    32   width of performance counters
// PORTS
//  clk              in   1   core clock; sole clock domain
//  reset_n          in   1   synchronous, active-low reset
//  id_valid         in   1   ID stage holds a valid instruction
//  id_rs1_addr      in   5   ID source register 1
//  id_rs2_addr      in   5   ID source register 2
//  id_uses_rs1      in   1   ID instruction reads rs1
//  id_uses_rs2      in   1   ID instruction reads rs2
//  ex_valid         in   1   EX stage holds a valid instruction
//  ex_rd_addr       in   5   EX destination register
//  ex_mem_read      in   1   EX instruction is a load
//  ex_branch_taken  in   1   EX resolved a taken branch/jump
//  ex_mc_start      in   1   pulse: EX instruction starts a multi-cycle op
//  ex_mc_done       in   1   pulse: multi-cycle result ready
//  dmem_busy        in   1   MEM-stage access not yet complete
//  imem_ready       in   1   fetch data valid this cycle
//  pc_en            out  1   PC register update enable
//  pc_redirect      out  1   PC selects branch target from EX
//  ifid_stall       out  1   hold IF/ID
//  ifid_flush       out  1   bubble IF/ID
//  idex_stall       out  1   hold ID/EX
//  idex_flush       out  1   bubble ID/EX
//  exmem_stall      out  1   hold EX/MEM
//  exmem_flush      out  1   bubble EX/MEM
//  memwb_flush      out  1   bubble MEM/WB
//  state_o          out  2   current FSM state (debug)
//  mc_timeout_err   out  1   sticky watchdog error
//  perf_stall_cyc   out  CNT_WIDTH  cycles with pc_en=0
//  perf_redirects   out  CNT_WIDTH  count of taken redirects
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//  - state=RUN; counters and watchdog cleared; mc_timeout_err=0.
//  - While reset_n=0, all control outputs are forced to 0 except pc_en=0 and ifid_flush=idex_flush=1.
//  FSM states: RUN=0, MC_WAIT=1, MEM_WAIT=2.
//  - RUN->MC_WAIT on ex_mc_start & ex_valid & !ex_mc_done & !dmem_busy.
//  - MC_WAIT->RUN on ex_mc_done.
//  - Any state->MEM_WAIT on dmem_busy; MEM_WAIT->prior-op state when dmem_busy falls.
//  - If in MC_WAIT when entering MEM_WAIT, the controller returns to MC_WAIT, unless ex_mc_done arrived meanwhile; that done is latched.
//  Control outputs are combinational from state and inputs; zero-latency. The first matching priority applies:
//  1. MEM wait (dmem_busy):
//     - pc_en=0;
//     - ifid/idex/exmem_stall=1;
//     - memwb_flush=1.
//     - A taken branch is ignored; it is re-presented from the frozen EX.
//  2. MC wait (state==MC_WAIT, or a start pulse with no done in the same cycle):
//     - pc_en=0; ifid/idex_stall=1; exmem_flush=1.
//     - A done pulse releases the stall in the same cycle.
//  3. Redirect (ex_valid & ex_branch_taken):
//     - pc_en=1; pc_redirect=1; ifid_flush=idex_flush=1.
//     - Overrides load-use and fetch wait.
//  4. Load-use: ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & ((id_uses_rs1 & rs1==rd) | (id_uses_rs2 & rs2==rd)).
//     - pc_en=0; ifid_stall=1; idex_flush=1. Exactly one bubble.
//  5. Fetch wait (!imem_ready): pc_en=0; ifid_flush=1; downstream advances.
//  6. Otherwise: pc_en=1; all stalls and flushes 0.
//  Stall/flush on the same stage are never asserted together.
//  Watchdog:
//  - Counts cycles in MC_WAIT; cleared on leaving MC_WAIT.
//  - Reaching MC_TIMEOUT sets mc_timeout_err (sticky until reset). Operation continues.
//  Perf counters:
//  - perf_stall_cyc increments on cycles with pc_en=0 and reset_n=1.
//  - perf_redirects increments on cycles with pc_redirect=1.
//  - Both wrap modulo 2^CNT_WIDTH.
// STRUCTURE
//  - Shared constants header: FSM state encodings (ST_RUN/ST_MC_WAIT/ST_MEM_WAIT) and the x0 register index.
//  - One sub-module, hazard_perf_counters: the two counters plus wrap logic.
//  - FSM, priority mux and watchdog live in this module.
// TESTING
//  1. Load x5 in EX; ID add uses rs1=x5 -> exactly 1 cycle of pc_en=0, ifid_stall=1, idex_flush=1; perf_stall_cyc=1.
//  2. Load to x0 in EX; ID uses x0 -> no stall.
//  3. ex_branch_taken with load-use present and imem_ready=0 -> pc_redirect=1, ifid_flush=idex_flush=1, pc_en=1; perf_redirects +1.
//  4. ex_mc_start, then ex_mc_done 5 cycles later -> MC_WAIT for 5 cycles with exmem_flush=1; RUN on done cycle; no timeout.
//  5. MC_TIMEOUT=8, done never arrives -> mc_timeout_err=1 after 8 cycles, stays 1 after done; cleared only by reset_n=0.
//  6. dmem_busy rises during MC_WAIT for 3 cycles, done pulses inside -> MEM_WAIT with memwb_flush=1, then RUN (done latched).
//     Counter preloaded at 2^32-1 wraps to 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, the x0 index
// and the bundled per-stage control word.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MC_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic pc_redirect;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic exmem_flush;
        logic memwb_flush;
    } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard inputs from the pipeline and per-stage control outputs back to it.
interface pipeline_hazard_controller_if;

    logic       id_valid;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_valid;
    logic [4:0] ex_rd_addr;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       ex_mc_start;
    logic       ex_mc_done;
    logic       dmem_busy;
    logic       imem_ready;

    logic       pc_en;
    logic       pc_redirect;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_stall;
    logic       idex_flush;
    logic       exmem_stall;
    logic       exmem_flush;
    logic       memwb_flush;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_rd_addr, ex_mem_read, ex_branch_taken,
               ex_mc_start, ex_mc_done, dmem_busy, imem_ready,
        input  pc_en, pc_redirect, ifid_stall, ifid_flush, idex_stall,
               idex_flush, exmem_stall, exmem_flush, memwb_flush
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_rd_addr, ex_mem_read, ex_branch_taken,
               ex_mc_start, ex_mc_done, dmem_busy, imem_ready,
        output pc_en, pc_redirect, ifid_stall, ifid_flush, idex_stall,
               idex_flush, exmem_stall, exmem_flush, memwb_flush
    );

endinterface

// File: rtl/hazard_perf_counters.sv
// Stall-cycle and redirect performance counters; both wrap modulo 2^CNT_WIDTH.
module hazard_perf_counters #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    output logic [CNT_WIDTH-1:0] stall_cyc_o,
    output logic [CNT_WIDTH-1:0] redirects_o
);

    logic [CNT_WIDTH-1:0] stall_cyc_q;
    logic [CNT_WIDTH-1:0] redirects_q;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cyc_q <= '0;
            redirects_q <= '0;
        end else begin
            if (stall_i)    stall_cyc_q <= stall_cyc_q + 1'b1;
            if (redirect_i) redirects_q <= redirects_q + 1'b1;
        end
    end

    assign stall_cyc_o = stall_cyc_q;
    assign redirects_o = redirects_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Per-cycle stall/flush/PC control for the 5-stage pipeline, with a multi-cycle
// op FSM, MC_WAIT watchdog and performance counters.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pipeline_hazard_controller_if.slave hz,
    output logic [1:0]             state_o,
    output logic                   mc_timeout_err,
    output logic [CNT_WIDTH-1:0]   perf_stall_cyc,
    output logic [CNT_WIDTH-1:0]   perf_redirects
);

    localparam int             WD_W   = $clog2(MC_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MC_TIMEOUT);

    state_e          state_q, state_d, eff_state;
    logic            mc_pend_q, mc_pend_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            mc_start_ok, mc_wait, redirect, load_use;
    ctrl_t           ctrl;

    // MEM_WAIT behaves like the op state it interrupted once dmem_busy drops.
    always_comb begin
        eff_state = state_q;
        if (state_q == ST_MEM_WAIT) eff_state = mc_pend_q ? ST_MC_WAIT : ST_RUN;
    end

    assign mc_start_ok = hz.ex_mc_start & hz.ex_valid & ~hz.ex_mc_done;
    assign mc_wait     = (eff_state == ST_MC_WAIT) ? ~hz.ex_mc_done : mc_start_ok;
    assign redirect    = hz.ex_valid & hz.ex_branch_taken;
    assign load_use    = hz.ex_valid & hz.ex_mem_read & (hz.ex_rd_addr != REG_X0) & hz.id_valid &
                         ((hz.id_uses_rs1 & (hz.id_rs1_addr == hz.ex_rd_addr)) |
                          (hz.id_uses_rs2 & (hz.id_rs2_addr == hz.ex_rd_addr)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            mc_pend_q <= 1'b0;
            wd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_pend_q <= mc_pend_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = eff_state;
        mc_pend_d = 1'b0;
        if (hz.dmem_busy) begin
            state_d   = ST_MEM_WAIT;
            mc_pend_d = (eff_state == ST_MC_WAIT) & ~hz.ex_mc_done;
        end else if (eff_state == ST_RUN && mc_start_ok) begin
            state_d = ST_MC_WAIT;
        end else if (eff_state == ST_MC_WAIT && hz.ex_mc_done) begin
            state_d = ST_RUN;
        end
    end

    // Watchdog counts consecutive MC_WAIT cycles and saturates at the limit.
    always_comb begin
        wd_d  = '0;
        err_d = err_q;
        if (state_q == ST_MC_WAIT) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            if (wd_d == WD_MAX) err_d = 1'b1;
        end
    end

    always_comb begin
        ctrl = '0;
        if (!reset_n) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (hz.dmem_busy) begin
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_stall  = 1'b1;
            ctrl.exmem_stall = 1'b1;
            ctrl.memwb_flush = 1'b1;
        end else if (mc_wait) begin
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_stall  = 1'b1;
            ctrl.exmem_flush = 1'b1;
        end else if (redirect) begin
            ctrl.pc_en       = 1'b1;
            ctrl.pc_redirect = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
        end else if (load_use) begin
            ctrl.ifid_stall = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (!hz.imem_ready) begin
            ctrl.ifid_flush = 1'b1;
        end else begin
            ctrl.pc_en = 1'b1;
        end
    end

    assign hz.pc_en       = ctrl.pc_en;
    assign hz.pc_redirect = ctrl.pc_redirect;
    assign hz.ifid_stall  = ctrl.ifid_stall;
    assign hz.ifid_flush  = ctrl.ifid_flush;
    assign hz.idex_stall  = ctrl.idex_stall;
    assign hz.idex_flush  = ctrl.idex_flush;
    assign hz.exmem_stall = ctrl.exmem_stall;
    assign hz.exmem_flush = ctrl.exmem_flush;
    assign hz.memwb_flush = ctrl.memwb_flush;

    assign state_o        = state_q;
    assign mc_timeout_err = err_q;

    hazard_perf_counters #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall_i     (reset_n & ~ctrl.pc_en),
        .redirect_i  (ctrl.pc_redirect),
        .stall_cyc_o (perf_stall_cyc),
        .redirects_o (perf_redirects)
    );

endmodule
